// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x oversampling: synchronises rx, recovers frames,
// pulses data_valid on a good stop bit and framing_error on a bad one.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  // The start check fires on the tick that would advance tcnt to OVERSAMPLE/2-1.
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_reg, state_next;
  logic [1:0]           sync_reg;
  logic                 rx_s;
  logic [TW-1:0]        tcnt_reg, tcnt_next;
  logic [BW-1:0]        bcnt_reg, bcnt_next;
  logic [DATA_BITS-1:0] frame_reg, frame_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 ferr_reg, ferr_next;

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      sync_reg  <= 2'b11;
      tcnt_reg  <= '0;
      bcnt_reg  <= '0;
      frame_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sync_reg  <= {sync_reg[0], rx};
      tcnt_reg  <= tcnt_next;
      bcnt_reg  <= bcnt_next;
      frame_reg <= frame_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tcnt_next  = tcnt_reg;
    bcnt_next  = bcnt_reg;
    frame_next = frame_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    if (baud_tick) begin
      case (state_reg)
        S_IDLE: begin
          if (!rx_s) begin
            tcnt_next  = '0;
            state_next = S_START;
          end
        end
        S_START: begin
          if (tcnt_reg == T_MID) begin
            if (rx_s) begin
              state_next = S_IDLE;
            end else begin
              tcnt_next  = '0;
              bcnt_next  = '0;
              state_next = S_DATA;
            end
          end else begin
            tcnt_next = tcnt_reg + TW'(1);
          end
        end
        S_DATA: begin
          if (tcnt_reg == T_LAST) begin
            tcnt_next  = '0;
            frame_next = {rx_s, frame_reg[DATA_BITS-1:1]};
            bcnt_next  = bcnt_reg + BW'(1);
            if (bcnt_reg == B_LAST) begin
              state_next = S_STOP;
            end
          end else begin
            tcnt_next = tcnt_reg + TW'(1);
          end
        end
        S_STOP: begin
          if (tcnt_reg == T_LAST) begin
            tcnt_next = '0;
            if (rx_s) begin
              data_next  = frame_reg;
              valid_next = 1'b1;
              state_next = S_IDLE;
            end else begin
              ferr_next  = 1'b1;
              state_next = S_BREAK;
            end
          end else begin
            tcnt_next = tcnt_reg + TW'(1);
          end
        end
        S_BREAK: begin
          // A held-low line must go high on a tick before start detection resumes.
          if (rx_s) begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state_reg != S_IDLE);
    data          = data_reg;
    data_valid    = valid_reg;
    framing_error = ferr_reg;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames, hand-written corner cases and random
// frames checked against a frame-level model of expected pulses.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rx            (rx),
    .data          (data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // baud_tick: one clk high out of every four.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      baud_tick = (phase == 0);
      phase = (phase + 1) % 4;
    end
  end

  typedef struct {
    bit         ferr;
    logic [7:0] d;
  } ev_t;
  ev_t ev_q[$];

  int  busy_ticks = 0;
  int  last_busy_ticks = -1;
  bit  prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Records every output pulse cycle; a pulse held two cycles shows as two events.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      prev_busy  = 1'b0;
      busy_ticks = 0;
    end else begin
      if (data_valid && framing_error) begin
        errors++;
        $display("FAIL both_pulses: data_valid and framing_error high together");
      end
      if (data_valid) begin
        ev_q.push_back('{ferr: 1'b0, d: data});
        chk("busy_low_with_valid", {31'd0, busy}, 32'd0);
      end
      if (framing_error) ev_q.push_back('{ferr: 1'b1, d: data});
      if (busy && !prev_busy) busy_ticks = 0;
      if (busy && baud_tick) busy_ticks++;
      if (!busy && prev_busy) last_busy_ticks = busy_ticks;
      prev_busy = busy;
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit stop, input int bc);
    rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bc) @(negedge clk);
    end
    rx = stop;
    repeat (bc) @(negedge clk);
  endtask

  task automatic expect_event(input string name, input bit exp_ferr, input logic [7:0] exp_d);
    ev_t e;
    chk({name, "_count"}, ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      e = ev_q.pop_front();
      chk({name, "_kind"}, {31'd0, e.ferr}, {31'd0, exp_ferr});
      chk({name, "_data"}, {24'd0, e.d}, {24'd0, exp_d});
    end
    ev_q.delete();
  endtask

  typedef struct {
    logic [7:0] tx_byte;
    bit         stop;
    int         bit_clks;
    int         gap_clks;
    bit         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [7:0] last_good;
    logic [7:0] rb;
    bit         rstop;
    int         rbc;
    int         rgap;

    vecs[0] = '{8'hA5, 1'b1, 64, 40, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 64, 0,  1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 64, 40, 1'b0, 8'hFF};
    vecs[3] = '{8'h55, 1'b1, 66, 40, 1'b0, 8'h55};
    vecs[4] = '{8'h55, 1'b1, 62, 40, 1'b0, 8'h55};
    vecs[5] = '{8'hC3, 1'b0, 64, 100, 1'b1, 8'h55};
    vecs[6] = '{8'h81, 1'b1, 64, 40, 1'b0, 8'h81};

    // Reset state
    repeat (5) @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, data_valid}, 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_events", ev_q.size(), 0);

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].tx_byte, vecs[v].stop, vecs[v].bit_clks);
      expect_event($sformatf("vec%0d", v), vecs[v].exp_ferr, vecs[v].exp_data);
      if (!vecs[v].stop) chk($sformatf("vec%0d_busy_break", v), {31'd0, busy}, 32'd1);
      else chk($sformatf("vec%0d_sample_tick", v), last_busy_ticks, 151);
      rx = 1'b1;
      repeat (vecs[v].gap_clks) @(negedge clk);
      chk($sformatf("vec%0d_no_extra", v), ev_q.size(), 0);
    end
    chk("after_table_busy", {31'd0, busy}, 32'd0);

    // False start: low for 5 ticks only
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("false_start_events", ev_q.size(), 0);
    chk("false_start_busy", {31'd0, busy}, 32'd0);
    chk("false_start_ticks", last_busy_ticks, 7);

    // Bad stop bit followed by a 40-tick break
    send_frame(8'h3C, 1'b0, 64);
    repeat (160) @(negedge clk);
    expect_event("break_ferr", 1'b1, 8'h81);
    chk("break_busy", {31'd0, busy}, 32'd1);
    chk("break_data_held", {24'd0, data}, 32'h81);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("break_exit_busy", {31'd0, busy}, 32'd0);
    chk("break_no_extra", ev_q.size(), 0);
    send_frame(8'h81, 1'b1, 64);
    expect_event("after_break", 1'b0, 8'h81);
    repeat (40) @(negedge clk);

    // Reset asserted during data bit 3
    fork
      send_frame(8'h5A, 1'b1, 64);
      begin
        repeat (288) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset_data", {24'd0, data}, 32'd0);
        chk("midreset_valid", {31'd0, data_valid}, 32'd0);
        chk("midreset_ferr", {31'd0, framing_error}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
      end
    join
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("midreset_no_pulse", ev_q.size(), 0);
    send_frame(8'h5A, 1'b1, 64);
    expect_event("after_reset", 1'b0, 8'h5A);
    repeat (40) @(negedge clk);

    // Random frames against the frame-level model
    last_good = 8'h5A;
    rstop = 1'b1;
    for (int n = 0; n < 14; n++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rbc   = $urandom_range(62, 66);
      send_frame(rb, rstop, rbc);
      if (rstop) last_good = rb;
      expect_event($sformatf("rand%0d", n), !rstop, last_good);
      rx = 1'b1;
      rgap = rstop ? $urandom_range(0, 100) : $urandom_range(64, 200);
      repeat (rgap) @(negedge clk);
    end
    repeat (100) @(negedge clk);
    chk("final_events", ev_q.size(), 0);
    chk("final_data", {24'd0, data}, {24'd0, last_good});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
